aes128_ctrl: RTL and testbench
==============================

AES128_CTRL -- requirements
Module: aes128_ctrl

Interface
REQ-001 SHALL have parameter NR, default 10, number of AES-128 rounds; only the value 10 is supported.
REQ-002 SHALL have port i_clk, input, 1: clock, rising edge.
REQ-003 SHALL have port i_rst, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port i_key, input, 128: cipher key.
REQ-005 SHALL have port i_key_load, input, 1: key-load request pulse.
REQ-006 SHALL have port i_din, input, 128: plaintext block.
REQ-007 SHALL have port i_din_vld, input, 1: plaintext valid.
REQ-008 SHALL have port o_din_rdy, output, 1: plaintext ready.
REQ-009 SHALL have port o_dout, output, 128: ciphertext; pass-through of i_rd_state.
REQ-010 SHALL have port o_dout_vld, output, 1: ciphertext valid.
REQ-011 SHALL have port i_dout_rdy, input, 1: ciphertext accepted.
REQ-012 SHALL have port o_key_ok, output, 1: round keys valid.
REQ-013 SHALL have port o_busy, output, 1: key expansion or encryption in progress.
REQ-014 SHALL have port o_err, output, 1: sticky S-box conflict flag.
REQ-015 SHALL have port o_kx_key_en, output, 1: key-expander start pulse.
REQ-016 SHALL have port i_kx_key_ok, input, 1: key-expander done.
REQ-017 SHALL have port i_exkey, input, 1408: round keys; round key r occupies bits [1407-128r -: 128], r=0..10.
REQ-018 SHALL have port i_kx_sbox_use, input, 1: key-expander S-box request.
REQ-019 SHALL have port i_kx_sbox_din, input, 32: key-expander S-box input word.
REQ-020 SHALL have port o_kx_sbox_dout, output, 32: S-box result returned to the key expander.
REQ-021 SHALL have port o_sbox_din, output, 32: input word to the shared 4-byte combinational S-box.
REQ-022 SHALL have port i_sbox_dout, input, 32: shared S-box output.
REQ-023 SHALL have port o_rd_load, output, 1: datapath load (state = i_din ^ rkey).
REQ-024 SHALL have port o_rd_sub, output, 1: datapath SubBytes on word o_rd_widx.
REQ-025 SHALL have port o_rd_widx, output, 2: word index.
REQ-026 SHALL have port o_rd_mix, output, 1: datapath ShiftRows / MixColumns / AddRoundKey step.
REQ-027 SHALL have port o_rd_last, output, 1: final round; the datapath skips MixColumns.
REQ-028 SHALL have port o_rd_round, output, 4: current round, 1..10.
REQ-029 SHALL have port o_rd_rkey, output, 128: round key for the load or mix step.
REQ-030 SHALL have port i_rd_sbox_din, input, 32: datapath word selected by o_rd_widx.
REQ-031 SHALL have port o_rd_sbox_dout, output, 32: S-box result returned to the datapath.

Function
REQ-032 SHALL implement FSM states IDLE, KEYEX, READY, SUB, MIX, OUT.
REQ-033 SHALL, in IDLE or READY on i_key_load=1, pulse o_kx_key_en for 1 cycle, clear o_key_ok and go to KEYEX; i_key_load in any other state is ignored.
REQ-034 SHALL, in KEYEX, wait for i_kx_key_ok=1, then set o_key_ok=1 and go to READY.
REQ-035 SHALL drive o_din_rdy = (state==READY) & ~i_key_load; a simultaneous key load wins and the block is not accepted.
REQ-036 SHALL, on READY with i_din_vld & o_din_rdy, pulse o_rd_load with o_rd_rkey = round key 0, set round=1, widx=0 and go to SUB.
REQ-037 SHALL, in SUB, assert o_rd_sub for 4 cycles with widx 0,1,2,3, then go to MIX.
REQ-038 SHALL, in MIX, assert o_rd_mix for 1 cycle with o_rd_rkey = round key[round] and o_rd_last = (round==10); if round<10, increment round and go to SUB, otherwise go to OUT.
REQ-039 SHALL, in OUT, assert o_dout_vld and hold it until i_dout_rdy=1, then go to READY.
REQ-040 SHALL assert o_dout_vld exactly 51 cycles after the acceptance edge.
REQ-041 SHALL drive the S-box mux as o_sbox_din = i_kx_sbox_use ? i_kx_sbox_din : i_rd_sbox_din.
REQ-042 SHALL broadcast i_sbox_dout to both o_kx_sbox_dout and o_rd_sbox_dout.
REQ-043 SHALL set o_err (sticky) when i_kx_sbox_use=1 while state==SUB; the key expander keeps priority.
REQ-044 SHALL drive o_busy = (state is KEYEX, SUB, MIX or OUT).
REQ-045 SHALL drive o_rd_rkey to 0 outside load and mix cycles.

Reset
REQ-046 SHALL, on i_rst, force state=IDLE, round=0, widx=0, and set o_key_ok, o_err, o_busy, o_din_rdy, o_dout_vld, o_kx_key_en, o_rd_load, o_rd_sub and o_rd_mix all to 0, asynchronously.
REQ-047 SHALL, after reset mid-operation, discard the in-flight block and require a new key load before any block is accepted.

Verification
REQ-048 SHALL pass: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> o_dout=69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-049 SHALL pass: acceptance at edge T -> o_rd_mix at T+5, T+10, ..., T+50; o_rd_last only at T+50; o_dout_vld at T+51.
REQ-050 SHALL pass: i_dout_rdy held low 5 cycles -> o_dout stable, o_din_rdy=0; i_dout_rdy=1 -> READY next cycle.
REQ-051 SHALL pass: i_key_load and i_din_vld both 1 in READY -> o_din_rdy=0, o_kx_key_en pulses, o_key_ok=0 until i_kx_key_ok.
REQ-052 SHALL pass: i_rst asserted during SUB of round 4 -> all outputs 0 immediately; i_din_vld then held 1 -> not accepted until key reloaded.
REQ-053 SHALL pass: i_kx_sbox_use forced 1 during SUB -> o_sbox_din=i_kx_sbox_din, o_err=1 and held until reset.

Source files
------------

// File: rtl/aes128_ctrl.sv
// AES-128 encryption controller.
// Sequences an external round datapath (load, word-serial SubBytes, combined
// ShiftRows/MixColumns/AddRoundKey step) and arbitrates a single shared 4-byte
// S-box between that datapath and an external key expander.
module aes128_ctrl #(
    parameter int NR = 10
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [127:0]            i_key,
    input  logic                    i_key_load,
    input  logic [127:0]            i_din,
    input  logic                    i_din_vld,
    output logic                    o_din_rdy,
    output logic [127:0]            o_dout,
    output logic                    o_dout_vld,
    input  logic                    i_dout_rdy,
    output logic                    o_key_ok,
    output logic                    o_busy,
    output logic                    o_err,
    output logic                    o_kx_key_en,
    input  logic                    i_kx_key_ok,
    input  logic [128*(NR+1)-1:0]   i_exkey,
    input  logic                    i_kx_sbox_use,
    input  logic [31:0]             i_kx_sbox_din,
    output logic [31:0]             o_kx_sbox_dout,
    output logic [31:0]             o_sbox_din,
    input  logic [31:0]             i_sbox_dout,
    output logic                    o_rd_load,
    output logic                    o_rd_sub,
    output logic [1:0]              o_rd_widx,
    output logic                    o_rd_mix,
    output logic                    o_rd_last,
    output logic [3:0]              o_rd_round,
    output logic [127:0]            o_rd_rkey,
    input  logic [127:0]            i_rd_state,
    input  logic [31:0]             i_rd_sbox_din,
    output logic [31:0]             o_rd_sbox_dout
);

    localparam logic [3:0] LAST_ROUND = 4'(NR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEYEX,
        S_READY,
        S_SUB,
        S_MIX,
        S_OUT
    } state_t;

    state_t       state_reg, state_next;
    logic [3:0]   round_reg, round_next;
    logic [1:0]   widx_reg, widx_next;
    logic         key_ok_reg, key_ok_next;
    logic         err_reg, err_next;

    logic         din_rdy;
    logic         dout_vld;
    logic         busy;
    logic         kx_key_en;
    logic         rd_load;
    logic         rd_sub;
    logic         rd_mix;
    logic         rd_last;
    logic [127:0] rd_rkey;

    // The raw key is consumed by the external key expander only.
    logic         unused_key_bits;
    assign unused_key_bits = ^i_key;

    // Round key r sits at the top of the bus for r=0 and walks downwards.
    logic [127:0] rkey_arr [0:NR];
    for (genvar gi = 0; gi <= NR; gi++) begin : g_rkey
        assign rkey_arr[gi] = i_exkey[128*(NR+1)-1-128*gi -: 128];
    end

    // State, counters and sticky flags; reset takes effect without a clock.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg  <= S_IDLE;
            round_reg  <= 4'd0;
            widx_reg   <= 2'd0;
            key_ok_reg <= 1'b0;
            err_reg    <= 1'b0;
        end else begin
            state_reg  <= state_next;
            round_reg  <= round_next;
            widx_reg   <= widx_next;
            key_ok_reg <= key_ok_next;
            err_reg    <= err_next;
        end
    end

    // Next-state logic and datapath strobes.
    always_comb begin
        state_next  = state_reg;
        round_next  = round_reg;
        widx_next   = widx_reg;
        key_ok_next = key_ok_reg;
        din_rdy     = 1'b0;
        dout_vld    = 1'b0;
        busy        = 1'b0;
        kx_key_en   = 1'b0;
        rd_load     = 1'b0;
        rd_sub      = 1'b0;
        rd_mix      = 1'b0;
        rd_last     = 1'b0;
        rd_rkey     = 128'd0;

        case (state_reg)
            S_IDLE: begin
                if (i_key_load) begin
                    kx_key_en   = 1'b1;
                    key_ok_next = 1'b0;
                    state_next  = S_KEYEX;
                end
            end
            S_KEYEX: begin
                busy = 1'b1;
                if (i_kx_key_ok) begin
                    key_ok_next = 1'b1;
                    state_next  = S_READY;
                end
            end
            S_READY: begin
                // A key load in the same cycle as a block wins.
                din_rdy = ~i_key_load;
                if (i_key_load) begin
                    kx_key_en   = 1'b1;
                    key_ok_next = 1'b0;
                    state_next  = S_KEYEX;
                end else if (i_din_vld) begin
                    rd_load    = 1'b1;
                    rd_rkey    = rkey_arr[0];
                    round_next = 4'd1;
                    widx_next  = 2'd0;
                    state_next = S_SUB;
                end
            end
            S_SUB: begin
                busy      = 1'b1;
                rd_sub    = 1'b1;
                widx_next = widx_reg + 2'd1;
                if (widx_reg == 2'd3) begin
                    state_next = S_MIX;
                end
            end
            S_MIX: begin
                busy    = 1'b1;
                rd_mix  = 1'b1;
                rd_rkey = rkey_arr[round_reg];
                rd_last = (round_reg == LAST_ROUND);
                if (round_reg == LAST_ROUND) begin
                    state_next = S_OUT;
                end else begin
                    round_next = round_reg + 4'd1;
                    state_next = S_SUB;
                end
            end
            S_OUT: begin
                busy     = 1'b1;
                dout_vld = 1'b1;
                if (i_dout_rdy) begin
                    state_next = S_READY;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // A key-expander S-box request during SubBytes steals the S-box: flag it.
    always_comb begin
        err_next = err_reg | (i_kx_sbox_use & (state_reg == S_SUB));
    end

    assign o_sbox_din     = i_kx_sbox_use ? i_kx_sbox_din : i_rd_sbox_din;
    assign o_kx_sbox_dout = i_sbox_dout;
    assign o_rd_sbox_dout = i_sbox_dout;

    assign o_dout      = i_rd_state;
    assign o_din_rdy   = din_rdy;
    assign o_dout_vld  = dout_vld;
    assign o_busy      = busy;
    // The start pulse is combinational from i_key_load; keep it quiet in reset.
    assign o_kx_key_en = kx_key_en & ~i_rst;
    assign o_key_ok    = key_ok_reg;
    assign o_err       = err_reg;
    assign o_rd_load   = rd_load;
    assign o_rd_sub    = rd_sub;
    assign o_rd_mix    = rd_mix;
    assign o_rd_last   = rd_last;
    assign o_rd_rkey   = rd_rkey;
    assign o_rd_widx   = widx_reg;
    assign o_rd_round  = round_reg;

endmodule

// File: tb/tb_aes128_ctrl.sv
// Testbench for aes128_ctrl: surrounds the controller with a behavioural
// S-box, round datapath and key expander, then drives directed scenarios.
module tb_aes128_ctrl;

    localparam logic [127:0] KEY_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT_A  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT_A  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic            i_clk = 1'b0;
    logic            i_rst;
    logic [127:0]    i_key;
    logic            i_key_load;
    logic [127:0]    i_din;
    logic            i_din_vld;
    logic            o_din_rdy;
    logic [127:0]    o_dout;
    logic            o_dout_vld;
    logic            i_dout_rdy;
    logic            o_key_ok;
    logic            o_busy;
    logic            o_err;
    logic            o_kx_key_en;
    logic            i_kx_key_ok;
    logic [1407:0]   i_exkey;
    logic            i_kx_sbox_use;
    logic [31:0]     i_kx_sbox_din;
    logic [31:0]     o_kx_sbox_dout;
    logic [31:0]     o_sbox_din;
    logic [31:0]     i_sbox_dout;
    logic            o_rd_load;
    logic            o_rd_sub;
    logic [1:0]      o_rd_widx;
    logic            o_rd_mix;
    logic            o_rd_last;
    logic [3:0]      o_rd_round;
    logic [127:0]    o_rd_rkey;
    logic [127:0]    i_rd_state;
    logic [31:0]     i_rd_sbox_din;
    logic [31:0]     o_rd_sbox_dout;

    int checks = 0;
    int errors = 0;

    aes128_ctrl #(.NR(10)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_key(i_key), .i_key_load(i_key_load),
        .i_din(i_din), .i_din_vld(i_din_vld), .o_din_rdy(o_din_rdy),
        .o_dout(o_dout), .o_dout_vld(o_dout_vld), .i_dout_rdy(i_dout_rdy),
        .o_key_ok(o_key_ok), .o_busy(o_busy), .o_err(o_err),
        .o_kx_key_en(o_kx_key_en), .i_kx_key_ok(i_kx_key_ok), .i_exkey(i_exkey),
        .i_kx_sbox_use(i_kx_sbox_use), .i_kx_sbox_din(i_kx_sbox_din),
        .o_kx_sbox_dout(o_kx_sbox_dout), .o_sbox_din(o_sbox_din),
        .i_sbox_dout(i_sbox_dout), .o_rd_load(o_rd_load), .o_rd_sub(o_rd_sub),
        .o_rd_widx(o_rd_widx), .o_rd_mix(o_rd_mix), .o_rd_last(o_rd_last),
        .o_rd_round(o_rd_round), .o_rd_rkey(o_rd_rkey), .i_rd_state(i_rd_state),
        .i_rd_sbox_din(i_rd_sbox_din), .o_rd_sbox_dout(o_rd_sbox_dout)
    );

    always #5 i_clk = ~i_clk;

    // ---------------- behavioural AES pieces ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        p = 8'h00; aa = a; bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
            bb = {1'b0, bb[7:1]};
        end
        return p;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r, p;
        r = 8'h01; p = x;
        for (int i = 0; i < 8; i++) begin
            if (i >= 1) r = gmul(r, p);
            p = gmul(p, p);
        end
        return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]}
                 ^ {r[3:0], r[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] sbox4(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [1407:0] key_expand(input logic [127:0] k);
        logic [31:0]   w [0:43];
        logic [31:0]   t;
        logic [7:0]    rc;
        logic [1407:0] ek;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t  = sbox4({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        for (int i = 0; i < 44; i++) ek[1407-32*i -: 32] = w[i];
        return ek;
    endfunction

    function automatic logic [127:0] round_fn(input logic [127:0] st,
                                              input logic [127:0] rk,
                                              input logic last);
        logic [7:0]   b [0:15];
        logic [7:0]   a0, a1, a2, a3;
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                b[4*c+r] = st[127-8*(4*((c+r)%4)+r) -: 8];
        for (int c = 0; c < 4; c++) begin
            a0 = b[4*c]; a1 = b[4*c+1]; a2 = b[4*c+2]; a3 = b[4*c+3];
            if (!last) begin
                b[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
                b[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
                b[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
                b[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = b[i];
        return o ^ rk;
    endfunction

    // Shared combinational S-box.
    always_comb i_sbox_dout = sbox4(o_sbox_din);

    // Round datapath state and its word-select mux.
    logic [127:0] dp_state = 128'd0;
    assign i_rd_state = dp_state;
    always_comb begin
        case (o_rd_widx)
            2'd0:    i_rd_sbox_din = dp_state[127:96];
            2'd1:    i_rd_sbox_din = dp_state[95:64];
            2'd2:    i_rd_sbox_din = dp_state[63:32];
            default: i_rd_sbox_din = dp_state[31:0];
        endcase
    end

    // Round datapath register updates.
    always_ff @(posedge i_clk) begin
        if (o_rd_load) begin
            dp_state <= i_din ^ o_rd_rkey;
        end else if (o_rd_sub) begin
            case (o_rd_widx)
                2'd0:    dp_state[127:96] <= o_rd_sbox_dout;
                2'd1:    dp_state[95:64]  <= o_rd_sbox_dout;
                2'd2:    dp_state[63:32]  <= o_rd_sbox_dout;
                default: dp_state[31:0]   <= o_rd_sbox_dout;
            endcase
        end else if (o_rd_mix) begin
            dp_state <= round_fn(dp_state, o_rd_rkey, o_rd_last);
        end
    end

    task automatic set_key(input logic [127:0] k);
        i_key   = k;
        i_exkey = key_expand(k);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        i_key_load = 1'b1;
        i_din_vld  = 1'b1;
        #1;
        checks++; if (o_key_ok !== 1'b0)    begin errors++; $display("FAIL reset_key_ok got %b want 0", o_key_ok); end
        checks++; if (o_err !== 1'b0)       begin errors++; $display("FAIL reset_err got %b want 0", o_err); end
        checks++; if (o_busy !== 1'b0)      begin errors++; $display("FAIL reset_busy got %b want 0", o_busy); end
        checks++; if (o_din_rdy !== 1'b0)   begin errors++; $display("FAIL reset_din_rdy got %b want 0", o_din_rdy); end
        checks++; if (o_dout_vld !== 1'b0)  begin errors++; $display("FAIL reset_dout_vld got %b want 0", o_dout_vld); end
        checks++; if (o_kx_key_en !== 1'b0) begin errors++; $display("FAIL reset_kx_key_en got %b want 0", o_kx_key_en); end
        checks++; if ({o_rd_load, o_rd_sub, o_rd_mix} !== 3'b000)
            begin errors++; $display("FAIL reset_rd_strobes got %b want 000", {o_rd_load, o_rd_sub, o_rd_mix}); end
        checks++; if ({o_rd_round, o_rd_widx} !== 6'd0)
            begin errors++; $display("FAIL reset_round_widx got %h want 0", {o_rd_round, o_rd_widx}); end
        checks++; if (o_rd_rkey !== 128'd0) begin errors++; $display("FAIL reset_rkey got %h want 0", o_rd_rkey); end
        i_key_load = 1'b0;
        i_din_vld  = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic test_idle_no_accept();
        i_din     = PT_A;
        i_din_vld = 1'b1;
        #1;
        checks++; if (o_din_rdy !== 1'b0) begin errors++; $display("FAIL idle_din_rdy got %b want 0", o_din_rdy); end
        checks++; if (o_rd_load !== 1'b0) begin errors++; $display("FAIL idle_rd_load got %b want 0", o_rd_load); end
        @(posedge i_clk); @(negedge i_clk);
        checks++; if (o_busy !== 1'b0) begin errors++; $display("FAIL idle_busy got %b want 0", o_busy); end
        i_din_vld = 1'b0;
    endtask

    task automatic test_key_load(input logic [127:0] k);
        set_key(k);
        i_key_load = 1'b1;
        #1;
        checks++; if (o_kx_key_en !== 1'b1) begin errors++; $display("FAIL kl_kx_key_en got %b want 1", o_kx_key_en); end
        @(posedge i_clk); @(negedge i_clk);
        i_key_load = 1'b0;
        #1;
        checks++; if ({o_kx_key_en, o_busy, o_key_ok} !== 3'b010)
            begin errors++; $display("FAIL kl_keyex got en/busy/ok %b want 010", {o_kx_key_en, o_busy, o_key_ok}); end
        // Key expander uses the S-box outside SubBytes: no conflict.
        i_kx_sbox_use = 1'b1;
        i_kx_sbox_din = 32'h53000102;
        #1;
        checks++; if (o_sbox_din !== 32'h53000102) begin errors++; $display("FAIL kl_sbox_din got %h want 53000102", o_sbox_din); end
        checks++; if (o_kx_sbox_dout !== 32'hed637c77) begin errors++; $display("FAIL kl_kx_sbox_dout got %h want ed637c77", o_kx_sbox_dout); end
        repeat (3) begin
            @(posedge i_clk); @(negedge i_clk);
            checks++; if (o_key_ok !== 1'b0) begin errors++; $display("FAIL kl_wait_key_ok got %b want 0", o_key_ok); end
        end
        i_kx_sbox_use = 1'b0;
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL kl_err got %b want 0", o_err); end
        i_kx_key_ok = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_kx_key_ok = 1'b0;
        #1;
        checks++; if ({o_key_ok, o_din_rdy, o_busy} !== 3'b110)
            begin errors++; $display("FAIL kl_done got ok/rdy/busy %b want 110", {o_key_ok, o_din_rdy, o_busy}); end
    endtask

    task automatic test_encrypt_timing(input logic [127:0] pt, input logic [127:0] ct, input logic [127:0] k);
        logic       exp_mix, exp_sub;
        logic [3:0] exp_round;
        i_dout_rdy = 1'b0;
        i_din      = pt;
        i_din_vld  = 1'b1;
        #1;
        checks++; if ({o_din_rdy, o_rd_load} !== 2'b11) begin errors++; $display("FAIL acc_load got rdy/load %b want 11", {o_din_rdy, o_rd_load}); end
        checks++; if (o_rd_rkey !== k) begin errors++; $display("FAIL acc_rkey0 got %h want %h", o_rd_rkey, k); end
        @(posedge i_clk); @(negedge i_clk);
        i_din_vld = 1'b0;
        for (int t = 1; t <= 51; t++) begin
            exp_mix   = (t % 5 == 0) && (t <= 50);
            exp_sub   = (t % 5 != 0) && (t < 51);
            exp_round = 4'((t - 1) / 5 + 1);
            checks++; if (o_rd_mix !== exp_mix) begin errors++; $display("FAIL tim_mix T+%0d got %b want %b", t, o_rd_mix, exp_mix); end
            checks++; if (o_rd_last !== (t == 50)) begin errors++; $display("FAIL tim_last T+%0d got %b want %b", t, o_rd_last, (t == 50)); end
            checks++; if (o_dout_vld !== (t == 51)) begin errors++; $display("FAIL tim_vld T+%0d got %b want %b", t, o_dout_vld, (t == 51)); end
            checks++; if (o_rd_sub !== exp_sub) begin errors++; $display("FAIL tim_sub T+%0d got %b want %b", t, o_rd_sub, exp_sub); end
            if (exp_sub) begin
                checks++; if ({o_rd_round, o_rd_widx} !== {exp_round, 2'(t % 5 - 1)})
                    begin errors++; $display("FAIL tim_round_widx T+%0d got %h want %h", t, {o_rd_round, o_rd_widx}, {exp_round, 2'(t % 5 - 1)}); end
                checks++; if (o_rd_rkey !== 128'd0) begin errors++; $display("FAIL tim_rkey_idle T+%0d got %h want 0", t, o_rd_rkey); end
            end
            if (exp_mix) begin
                checks++; if (o_rd_rkey !== i_exkey[1407-128*(t/5) -: 128])
                    begin errors++; $display("FAIL tim_rkey T+%0d got %h want %h", t, o_rd_rkey, i_exkey[1407-128*(t/5) -: 128]); end
            end
            if (t < 51) begin
                @(posedge i_clk); @(negedge i_clk);
            end
        end
        checks++; if (o_dout !== ct) begin errors++; $display("FAIL tim_dout got %h want %h", o_dout, ct); end
        $display("block pt=%h ct=%h", pt, o_dout);
    endtask

    task automatic test_backpressure(input logic [127:0] ct);
        repeat (5) begin
            @(posedge i_clk); @(negedge i_clk);
            checks++; if ({o_dout_vld, o_din_rdy} !== 2'b10) begin errors++; $display("FAIL bp_vld_rdy got %b want 10", {o_dout_vld, o_din_rdy}); end
            checks++; if (o_dout !== ct) begin errors++; $display("FAIL bp_dout got %h want %h", o_dout, ct); end
        end
        i_dout_rdy = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_dout_rdy = 1'b0;
        #1;
        checks++; if ({o_dout_vld, o_din_rdy, o_busy} !== 3'b010)
            begin errors++; $display("FAIL bp_release got vld/rdy/busy %b want 010", {o_dout_vld, o_din_rdy, o_busy}); end
    endtask

    task automatic test_key_collision(input logic [127:0] k, input logic [127:0] pt);
        set_key(k);
        i_din      = pt;
        i_din_vld  = 1'b1;
        i_key_load = 1'b1;
        #1;
        checks++; if ({o_din_rdy, o_rd_load, o_kx_key_en} !== 3'b001)
            begin errors++; $display("FAIL col_strobes got rdy/load/en %b want 001", {o_din_rdy, o_rd_load, o_kx_key_en}); end
        @(posedge i_clk); @(negedge i_clk);
        i_key_load = 1'b0;
        i_din_vld  = 1'b0;
        #1;
        checks++; if ({o_key_ok, o_busy, o_kx_key_en} !== 3'b010)
            begin errors++; $display("FAIL col_keyex got ok/busy/en %b want 010", {o_key_ok, o_busy, o_kx_key_en}); end
        repeat (2) begin
            @(posedge i_clk); @(negedge i_clk);
            checks++; if (o_key_ok !== 1'b0) begin errors++; $display("FAIL col_key_ok_wait got %b want 0", o_key_ok); end
        end
        i_kx_key_ok = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_kx_key_ok = 1'b0;
        checks++; if (o_key_ok !== 1'b1) begin errors++; $display("FAIL col_key_ok got %b want 1", o_key_ok); end
    endtask

    task automatic test_back_to_back(input logic [127:0] pt, input logic [127:0] ct);
        int cnt;
        i_dout_rdy = 1'b1;
        for (int b = 0; b < 2; b++) begin
            i_din     = pt;
            i_din_vld = 1'b1;
            #1;
            checks++; if (o_din_rdy !== 1'b1) begin errors++; $display("FAIL b2b_din_rdy blk%0d got %b want 1", b, o_din_rdy); end
            @(posedge i_clk); @(negedge i_clk);
            i_din_vld = 1'b0;
            cnt = 1;
            while (!o_dout_vld && cnt < 60) begin
                @(posedge i_clk); @(negedge i_clk);
                cnt++;
            end
            checks++; if (cnt !== 51) begin errors++; $display("FAIL b2b_latency blk%0d got %0d want 51", b, cnt); end
            checks++; if (o_dout !== ct) begin errors++; $display("FAIL b2b_dout blk%0d got %h want %h", b, o_dout, ct); end
            $display("block pt=%h ct=%h", pt, o_dout);
            @(posedge i_clk); @(negedge i_clk);
            checks++; if (o_din_rdy !== 1'b1) begin errors++; $display("FAIL b2b_ready_next blk%0d got %b want 1", b, o_din_rdy); end
        end
        i_dout_rdy = 1'b0;
    endtask

    task automatic test_sbox_conflict_reset();
        i_din     = PT_A;
        i_din_vld = 1'b1;
        @(posedge i_clk); @(negedge i_clk);
        i_din_vld = 1'b0;
        repeat (15) begin
            @(posedge i_clk); @(negedge i_clk);
        end
        checks++; if ({o_rd_sub, o_rd_round} !== 5'b1_0100)
            begin errors++; $display("FAIL cf_in_sub4 got sub/round %h want 14", {o_rd_sub, o_rd_round}); end
        i_kx_sbox_use = 1'b1;
        i_kx_sbox_din = 32'h00010203;
        #1;
        checks++; if (o_sbox_din !== 32'h00010203) begin errors++; $display("FAIL cf_sbox_din got %h want 00010203", o_sbox_din); end
        checks++; if (o_rd_sbox_dout !== 32'h637c777b) begin errors++; $display("FAIL cf_rd_sbox_dout got %h want 637c777b", o_rd_sbox_dout); end
        checks++; if (o_err !== 1'b0) begin errors++; $display("FAIL cf_err_early got %b want 0", o_err); end
        @(posedge i_clk); @(negedge i_clk);
        i_kx_sbox_use = 1'b0;
        checks++; if (o_err !== 1'b1) begin errors++; $display("FAIL cf_err_set got %b want 1", o_err); end
        @(posedge i_clk); @(negedge i_clk);
        checks++; if ({o_err, o_busy} !== 2'b11) begin errors++; $display("FAIL cf_err_hold got err/busy %b want 11", {o_err, o_busy}); end
        #2 i_rst = 1'b1;
        #1;
        checks++; if ({o_busy, o_din_rdy, o_dout_vld, o_kx_key_en, o_rd_load, o_rd_sub, o_rd_mix, o_key_ok, o_err} !== 9'd0)
            begin errors++; $display("FAIL rst_mid_outputs got %b want 000000000",
                {o_busy, o_din_rdy, o_dout_vld, o_kx_key_en, o_rd_load, o_rd_sub, o_rd_mix, o_key_ok, o_err}); end
        checks++; if ({o_rd_round, o_rd_widx} !== 6'd0) begin errors++; $display("FAIL rst_mid_counters got %h want 0", {o_rd_round, o_rd_widx}); end
        @(negedge i_clk);
        i_rst     = 1'b0;
        i_din_vld = 1'b1;
        repeat (5) begin
            @(posedge i_clk); @(negedge i_clk);
            checks++; if ({o_din_rdy, o_rd_load, o_busy} !== 3'b000)
                begin errors++; $display("FAIL rst_no_accept got rdy/load/busy %b want 000", {o_din_rdy, o_rd_load, o_busy}); end
        end
        i_din_vld = 1'b0;
    endtask

    initial begin
        i_rst         = 1'b1;
        i_key_load    = 1'b0;
        i_din         = 128'd0;
        i_din_vld     = 1'b0;
        i_dout_rdy    = 1'b0;
        i_kx_key_ok   = 1'b0;
        i_kx_sbox_use = 1'b0;
        i_kx_sbox_din = 32'd0;
        set_key(KEY_A);
        @(negedge i_clk);
        test_reset();
        test_idle_no_accept();
        test_key_load(KEY_A);
        test_encrypt_timing(PT_A, CT_A, KEY_A);
        test_backpressure(CT_A);
        test_key_collision(KEY_B, PT_B);
        test_back_to_back(PT_B, CT_B);
        test_sbox_conflict_reset();
        test_key_load(KEY_A);
        test_back_to_back(PT_A, CT_A);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
